// File: rtl/alu_md_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_md_iter
//  Description : EX-stage execute unit. Single-cycle integer ALU ops plus
//                RV32M multiply/divide done iteratively (radix-2, one bit per
//                cycle). Operands enter through a valid/ready handshake and
//                the result leaves through a second handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_md_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         overflow,
    output logic         busy
);

    localparam int SHW = $clog2(W);

    // Single-cycle op codes
    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_ADDO   = 5'b00001;
    localparam logic [4:0] OP_SUB    = 5'b00010;
    localparam logic [4:0] OP_SUBO   = 5'b00011;
    localparam logic [4:0] OP_AND    = 5'b00100;
    localparam logic [4:0] OP_OR     = 5'b00101;
    localparam logic [4:0] OP_XOR    = 5'b00110;
    localparam logic [4:0] OP_NOR    = 5'b00111;
    localparam logic [4:0] OP_SLTU   = 5'b01000;
    localparam logic [4:0] OP_SLT    = 5'b01001;
    localparam logic [4:0] OP_SLL    = 5'b01100;
    localparam logic [4:0] OP_SRL    = 5'b01101;
    localparam logic [4:0] OP_SRA    = 5'b01110;
    // Iterative op codes
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_REM    = 5'b10110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;

    // Iterative datapath state
    logic [2:0]       iter_op;     // low bits of the captured M-extension op
    logic [2*W-1:0]   acc;         // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [W-1:0]     mcand;       // mul: |multiplicand|; div: |divisor|
    logic             neg_prod;    // negate product / quotient at the end
    logic             neg_rem;     // negate remainder at the end
    logic             div_zero;    // divisor was zero
    logic [SHW-1:0]   cnt;

    // Handshake / status
    logic             accept;
    logic             is_iter;

    assign in_ready  = (state == IDLE) & ~rst;
    assign busy      = (state == CALC);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign is_iter   = (op[4:3] == 2'b10);

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [W-1:0]   sum;
    logic [W-1:0]   diff;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   alu_res;
    logic           alu_ovf;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SHW-1:0];

    // Combinational result for the single-cycle class; illegal codes give 0
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD:  alu_res = sum;
            OP_ADDO: begin
                alu_res = sum;
                alu_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB:  alu_res = diff;
            OP_SUBO: begin
                alu_res = diff;
                alu_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLTU: alu_res = {{(W-1){1'b0}}, (a < b)};
            OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning at accept: signedness and magnitudes
    // ------------------------------------------------------------------
    logic         a_signed;
    logic         b_signed;
    logic         sign_a;
    logic         sign_b;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;

    assign a_signed = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
    assign b_signed = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
    assign sign_a   = a[W-1] & a_signed;
    assign sign_b   = b[W-1] & b_signed;
    assign mag_a    = sign_a ? (~a + 1'b1) : a;
    assign mag_b    = sign_b ? (~b + 1'b1) : b;

    // ------------------------------------------------------------------
    // One radix-2 step of shift-add multiply or restoring divide
    // ------------------------------------------------------------------
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     rem_shift;
    logic [W+1:0]   div_diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] step_next;

    // Next accumulator value for the current iteration
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (mcand & {W{acc[0]}})};
        mul_next  = {mul_sum, acc[W-1:1]};
        rem_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = {1'b0, rem_shift} - {2'b00, mcand};
        if (div_diff[W+1])
            div_next = {rem_shift[W-1:0], acc[W-2:0], 1'b0};
        else
            div_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
        step_next = iter_op[2] ? div_next : mul_next;
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection after the last iteration
    // ------------------------------------------------------------------
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   fin_res;

    // Final M-extension result from the last step's accumulator
    always_comb begin
        prod_fixed = neg_prod ? (~step_next + 1'b1) : step_next;
        quo        = step_next[W-1:0];
        rem        = step_next[2*W-1:W];
        fin_res    = '0;
        case (iter_op)
            3'b000:                 fin_res = prod_fixed[W-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_fixed[2*W-1:W];
            3'b100, 3'b101:         fin_res = div_zero ? '1 : (neg_prod ? (~quo + 1'b1) : quo);
            default:                fin_res = neg_rem ? (~rem + 1'b1) : rem;
        endcase
    end

    // Control FSM and all registered datapath/result state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            iter_op  <= '0;
            neg_prod <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_iter) begin
                            state    <= CALC;
                            cnt      <= SHW'(W-1);
                            iter_op  <= op[2:0];
                            neg_prod <= sign_a ^ sign_b;
                            neg_rem  <= sign_a;
                            div_zero <= (b == '0);
                            // Divide shifts the dividend out of the low half;
                            // multiply shifts the multiplier out of it.
                            acc      <= {{W{1'b0}}, (op[2] ? mag_a : mag_b)};
                            mcand    <= op[2] ? mag_b : mag_a;
                        end else begin
                            state    <= DONE;
                            result   <= alu_res;
                            zero     <= (alu_res == '0);
                            overflow <= alu_ovf;
                        end
                    end
                end
                CALC: begin
                    acc <= step_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state    <= DONE;
                        result   <= fin_res;
                        zero     <= (fin_res == '0);
                        overflow <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_md_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_md_iter
//  Description : Self-checking bench for alu_md_iter (W=32). Directed cases
//                plus randomized ops compared against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_md_iter;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    alu_md_iter #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model computed directly from the arithmetic definitions
    task automatic model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic ov);
        logic [63:0] p;
        int          sx;
        int          sy;
        sx = x;
        sy = y;
        r  = 32'h0;
        ov = 1'b0;
        p  = 64'h0;
        case (o)
            5'd0:  r = x + y;
            5'd1:  begin r = x + y; ov = (x[31] == y[31]) && (r[31] != x[31]); end
            5'd2:  r = x - y;
            5'd3:  begin r = x - y; ov = (x[31] != y[31]) && (r[31] != x[31]); end
            5'd4:  r = x & y;
            5'd5:  r = x | y;
            5'd6:  r = x ^ y;
            5'd7:  r = ~(x | y);
            5'd8:  r = (x < y) ? 32'd1 : 32'd0;
            5'd9:  r = (sx < sy) ? 32'd1 : 32'd0;
            5'd12: r = x << y[4:0];
            5'd13: r = x >> y[4:0];
            5'd14: r = sx >>> y[4:0];
            5'd16: r = x * y;
            5'd17: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; r = p[63:32]; end
            5'd18: begin p = {{32{x[31]}}, x} * {32'h0, y};       r = p[63:32]; end
            5'd19: begin p = {32'h0, x} * {32'h0, y};             r = p[63:32]; end
            5'd20: begin
                if (y == 0)                                r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == '1)    r = x;
                else                                       r = sx / sy;
            end
            5'd21: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd22: begin
                if (y == 0)                                r = x;
                else if (x == 32'h8000_0000 && y == '1)    r = 32'h0;
                else                                       r = sx % sy;
            end
            5'd23: r = (y == 0) ? x : x % y;
            default: r = 32'h0;
        endcase
    endtask

    // Issue one op from a negedge in IDLE, check result/flags/latency, then
    // stall the output for 'dly' cycles before the output handshake.
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int dly);
        logic [31:0] er;
        logic        eo;
        int          lat;
        int          bcnt;
        int          exp_lat;
        model(o, x, y, er, eo);
        exp_lat = (o[4:3] == 2'b10) ? W + 1 : 1;
        check("in_ready_idle", {63'h0, in_ready}, 64'd1);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        op       = 5'($urandom_range(0, 31));
        lat      = 1;
        bcnt     = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency op%0d", o), 64'(lat), 64'(exp_lat));
        check($sformatf("busy_cycles op%0d", o), 64'(bcnt), 64'(exp_lat - 1));
        check($sformatf("result op%0d a=%h b=%h", o, x, y), {32'h0, result}, {32'h0, er});
        check($sformatf("zero op%0d", o), {63'h0, zero}, {63'h0, (er == 0)});
        check($sformatf("overflow op%0d", o), {63'h0, overflow}, {63'h0, eo});
        // Backpressure: result held, no new accept while DONE
        for (int k = 0; k < dly; k++) begin
            in_valid = 1'b1;
            op       = 5'd0;
            @(negedge clk);
            check("stall_valid", {63'h0, out_valid}, 64'd1);
            check("stall_in_ready", {63'h0, in_ready}, 64'd0);
            check("stall_busy", {63'h0, busy}, 64'd0);
            check("stall_result", {32'h0, result}, {32'h0, er});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", {63'h0, out_valid}, 64'd0);
        check("post_hs_in_ready", {63'h0, in_ready}, 64'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 5'd0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'h0, in_ready}, 64'd0);
        check("rst_out_valid", {63'h0, out_valid}, 64'd0);
        check("rst_busy", {63'h0, busy}, 64'd0);
        check("rst_result", {32'h0, result}, 64'd0);
        check("rst_zero", {63'h0, zero}, 64'd0);
        check("rst_overflow", {63'h0, overflow}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(5'b00001, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(5'b00011, 32'h8000_0000, 32'h0000_0001, 0);
        run_op(5'b00010, 32'd5, 32'd5, 0);
        run_op(5'b01110, 32'h8000_0000, 32'h24, 0);
        run_op(5'b01101, 32'h8000_0000, 32'h24, 0);
        run_op(5'b01001, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(5'b01000, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(5'b00111, 32'h0, 32'h0, 0);
        run_op(5'b11010, 32'h1234, 32'h5678, 0);
        run_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'b10100, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(5'b10110, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(5'b10101, 32'd7, 32'd0, 0);
        run_op(5'b10111, 32'd7, 32'd0, 0);
        run_op(5'b10100, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(5'b10110, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        // Backpressure followed by a back-to-back op
        run_op(5'b00001, 32'h7FFF_FFFF, 32'h0000_0001, 5);
        run_op(5'b00000, 32'd10, 32'd20, 0);

        // Reset in the middle of a DIVU
        check("in_ready_pre_divu", {63'h0, in_ready}, 64'd1);
        op       = 5'b10101;
        a        = 32'd1000;
        b        = 32'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_rst", {63'h0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {63'h0, out_valid}, 64'd0);
        check("midrst_busy", {63'h0, busy}, 64'd0);
        check("midrst_result", {32'h0, result}, 64'd0);
        check("midrst_zero", {63'h0, zero}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_in_ready", {63'h0, in_ready}, 64'd1);
        run_op(5'b10000, 32'd3, 32'd5, 0);

        // Randomized ops against the model
        for (int i = 0; i < 200; i++) begin
            run_op(5'($urandom_range(0, 31)), pick_operand(), pick_operand(),
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
